// File: rtl/vend_controller.sv
// Vending machine transaction controller: it sequences coin collection, price
// check, dispense handshake and change/refund against an external credit accumulator.
module vend_controller #(
  parameter logic [9:0]  PRICE_A     = 10'd50,
  parameter logic [9:0]  PRICE_B     = 10'd80,
  parameter logic [9:0]  PRICE_C     = 10'd100,
  parameter logic [9:0]  PRICE_D     = 10'd120,
  parameter logic [9:0]  PRICE_E     = 10'd150,
  parameter logic [2:0]  A           = 3'b001,
  parameter logic [2:0]  B           = 3'b011,
  parameter logic [2:0]  C           = 3'b010,
  parameter logic [2:0]  D           = 3'b110,
  parameter logic [2:0]  E           = 3'b111,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_coin_valid,
  input  logic [2:0]  i_coin,
  input  logic        i_sel_valid,
  input  logic [2:0]  i_sel,
  input  logic        i_cancel,
  input  logic        i_vend_ack,
  input  logic [31:0] i_collected,
  output logic        o_insert_en,
  output logic        o_col_rst,
  output logic        o_vend_valid,
  output logic [2:0]  o_vend_item,
  output logic        o_change_valid,
  output logic [31:0] o_change,
  output logic        o_busy,
  output logic        o_err_short,
  output logic        o_err_invalid
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_CHECK    = 3'd2,
    S_DISPENSE = 3'd3,
    S_CHANGE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_item;
  logic [9:0]  r_price;
  logic [31:0] r_change;
  logic        r_col_rst;

  logic        w_coin_acc;
  logic        w_sel_ok;
  logic [9:0]  w_sel_price;
  logic        w_timeout;
  logic        w_refund;
  logic        w_enough;

  // Coin codes are active-low one-cold; anything else is a jam or misread.
  function automatic logic f_coin_ok(input logic [2:0] coin);
    return (coin == 3'b110) || (coin == 3'b101) || (coin == 3'b011);
  endfunction

  assign w_coin_acc = i_coin_valid & f_coin_ok(i_coin) & ~i_cancel & ~i_rst &
                      ((r_state == S_IDLE) | (r_state == S_COLLECT));
  assign w_timeout  = (r_cnt == (TIMEOUT_CYC - 16'd1)) & ~w_coin_acc;
  assign w_refund   = (r_state == S_COLLECT) & (i_cancel | (~i_sel_valid & w_timeout));
  assign w_enough   = (i_collected >= {22'd0, r_price});

  always_comb begin
    w_sel_ok    = 1'b1;
    w_sel_price = '0;
    if      (i_sel == A) w_sel_price = PRICE_A;
    else if (i_sel == B) w_sel_price = PRICE_B;
    else if (i_sel == C) w_sel_price = PRICE_C;
    else if (i_sel == D) w_sel_price = PRICE_D;
    else if (i_sel == E) w_sel_price = PRICE_E;
    else                 w_sel_ok    = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_coin_acc) w_next_state = S_COLLECT;
      S_COLLECT: begin
        if (i_cancel)                      w_next_state = S_CHANGE;
        else if (i_sel_valid) begin
          if (w_sel_ok)                    w_next_state = S_CHECK;
        end
        else if (w_timeout)                w_next_state = S_CHANGE;
      end
      S_CHECK:    w_next_state = w_enough ? S_DISPENSE : S_COLLECT;
      S_DISPENSE: if (i_vend_ack) w_next_state = S_CHANGE;
      S_CHANGE:   w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_insert_en    = w_coin_acc;
    o_busy         = (r_state != S_IDLE);
    o_vend_valid   = (r_state == S_DISPENSE);
    o_change_valid = (r_state == S_CHANGE);
    o_err_short    = (r_state == S_CHECK) & ~w_enough;
    o_err_invalid  = (r_state == S_COLLECT) & i_sel_valid & ~w_sel_ok & ~i_cancel;
  end

  // Idle counter only runs in COLLECT, so leaving and re-entering clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                  r_cnt <= '0;
    else if (r_state != S_COLLECT || w_coin_acc) r_cnt <= '0;
    else                                        r_cnt <= r_cnt + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_item    <= '0;
      r_price   <= '0;
      r_change  <= '0;
      r_col_rst <= 1'b0;
    end else begin
      r_col_rst <= (w_next_state == S_CHANGE);
      if ((r_state == S_COLLECT) && !i_cancel && i_sel_valid && w_sel_ok) begin
        r_item  <= i_sel;
        r_price <= w_sel_price;
      end
      if (w_refund)
        r_change <= i_collected;
      else if ((r_state == S_CHECK) && w_enough)
        r_change <= i_collected - {22'd0, r_price};
    end
  end

  assign o_col_rst   = r_col_rst;
  assign o_vend_item = r_item;
  assign o_change    = r_change;

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameters PRICE_A=10'd50, PRICE_B=10'd80, PRICE_C=10'd100, PRICE_D=10'd120, PRICE_E=10'd150: item prices in cents.
REQ-002 SHALL have parameters A=3'b001, B=3'b011, C=3'b010, D=3'b110, E=3'b111: item select codes.
REQ-003 SHALL have parameter TIMEOUT_CYC=16'd50000: idle cycles in COLLECT before auto-refund.
REQ-004 SHALL have ports, clock and reset first:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_coin_valid  in  1  coin present this cycle.
- i_coin  in  3  active-low coin code: bit0 low=10, bit1 low=25, bit2 low=100.
- i_sel_valid  in  1  item selection strobe.
- i_sel  in  3  item select code.
- i_cancel  in  1  refund request.
- i_vend_ack  in  1  dispenser accepted the item.
- i_collected  in  32  running credit from the external coin accumulator.
- o_insert_en  out  1  accumulator add-enable.
- o_col_rst  out  1  accumulator clear, registered.
- o_vend_valid  out  1  dispense request.
- o_vend_item  out  3  item code being dispensed.
- o_change_valid  out  1  change/refund strobe.
- o_change  out  32  change/refund amount.
- o_busy  out  1  state is not IDLE.
- o_err_short  out  1  credit below price, pulse.
- o_err_invalid  out  1  unknown select code, pulse.

Function
REQ-005 SHALL implement the states IDLE, COLLECT, CHECK, DISPENSE and CHANGE.
REQ-006 A coin SHALL be valid only when exactly one bit of i_coin is low; invalid codes SHALL be ignored.
REQ-007 o_insert_en SHALL be combinational: i_coin_valid & valid coin & ~i_cancel & state in {IDLE, COLLECT}.
REQ-008 IDLE SHALL move to COLLECT on an accepted coin; selections in IDLE SHALL be ignored.
REQ-009 COLLECT priority SHALL be: i_cancel, then i_sel_valid, then timeout.
- i_cancel -> CHANGE, refund = i_collected.
- i_sel_valid with valid code -> latch the code, register the price, go to CHECK.
- i_sel_valid with unknown code -> o_err_invalid one cycle, stay in COLLECT.
- Timeout -> same as cancel.
REQ-010 A coin accepted in the same cycle as i_sel_valid SHALL count toward the price check.
REQ-011 The timeout counter SHALL be 16 bits.
- Clear on entry to COLLECT and on each accepted coin.
- Expire when it reaches TIMEOUT_CYC-1.
REQ-012 CHECK SHALL last one cycle.
- If i_collected >= price: go to DISPENSE, register o_change = i_collected - price.
- Otherwise: o_err_short one cycle, return to COLLECT, counter cleared.
REQ-013 In DISPENSE, o_vend_valid SHALL be 1 and o_vend_item SHALL hold the latched code until i_vend_ack.
REQ-014 i_vend_ack sampled in DISPENSE SHALL move to CHANGE; i_vend_ack outside DISPENSE SHALL be ignored.
REQ-015 i_cancel in CHECK or DISPENSE SHALL be ignored.
REQ-016 CHANGE SHALL last one cycle.
- o_change_valid=1 with o_change, including when the amount is 0.
- Return to IDLE.
REQ-017 o_col_rst SHALL be a flop output, high exactly during the CHANGE cycle, and glitch-free.
REQ-018 Comparison and subtraction SHALL be 32-bit unsigned, with the price zero-extended.
REQ-019 o_change SHALL hold its last value until the next CHECK or refund.

Reset
REQ-020 i_rst SHALL asynchronously force state IDLE, counter 0, latched item 0, and all outputs 0 (o_col_rst=0).
REQ-021 Reset mid-transaction SHALL abandon it with no vend and no change strobe; the accumulator is cleared by the system reset.

Verification
REQ-022 Coins 25, 25, then select A -> one CHECK cycle, o_vend_valid=1 with item 3'b001; after ack, o_change_valid with o_change=0 and one o_col_rst pulse.
REQ-023 Coin 100, select E -> o_err_short pulse, back to COLLECT; coin 100, select E -> vend item 3'b111, o_change=50.
REQ-024 Coins 10, 25, then i_cancel -> o_change_valid with o_change=35, no o_vend_valid, o_col_rst for 1 cycle.
REQ-025 TIMEOUT_CYC=8, coin 10, no activity -> refund of 10 exactly 8 cycles after the coin; a coin at cycle 5 restarts the count.
REQ-026 i_coin=3'b000 or 3'b111 -> o_insert_en=0; select 3'b000 in COLLECT -> o_err_invalid pulse, state unchanged.
REQ-027 i_rst asserted while o_vend_valid=1 -> all outputs 0 immediately (before the clock edge); o_busy=0 after release.
